// File: rtl/multi_level_thresh.sv
// multi_level_thresh: frame-latched split, ramped and multi-level thresholding
// for the camera pixel path, with a fixed two-cycle latency and no back-pressure.
module multi_level_thresh #(
   parameter int DATA_W     = 8,
   parameter int COORD_W    = 16,
   parameter int NUM_LEVELS = 4,
   parameter int SPLIT_Y    = 240,
   parameter int BAND_LOG2  = 6,
   parameter int FRAC_W     = 20
) (
   input  logic                                 iClk,
   input  logic                                 iRst_n,
   input  logic                                 iValid,
   input  logic [DATA_W-1:0]                    iGray,
   input  logic [COORD_W-1:0]                   iX_Cont,
   input  logic [COORD_W-1:0]                   iY_Cont,
   input  logic [1:0]                           iMode,
   input  logic [DATA_W-1:0]                    iThreshTop,
   input  logic [DATA_W-1:0]                    iThreshBot,
   input  logic [(NUM_LEVELS-1)*DATA_W-1:0]     iQThresh,
   output logic [DATA_W-1:0]                    oPixel,
   output logic [$clog2(NUM_LEVELS)-1:0]        oLevel,
   output logic                                 oValid,
   output logic [COORD_W-1:0]                   oX_Cont,
   output logic [COORD_W-1:0]                   oY_Cont
);

   localparam int LVL_W  = $clog2(NUM_LEVELS);
   localparam int NQ     = NUM_LEVELS - 1;
   localparam int ACC_W  = DATA_W + FRAC_W + 2;
   localparam int BAND_H = 1 << BAND_LOG2;
   localparam logic [COORD_W-1:0] SPLIT_ROW = COORD_W'(SPLIT_Y);
   localparam logic [COORD_W-1:0] BAND_LO   = COORD_W'(SPLIT_Y - BAND_H);
   localparam logic [COORD_W-1:0] BAND_HI   = COORD_W'(SPLIT_Y + BAND_H);

   typedef enum logic [1:0] {
      MODE_SPLIT = 2'd0,
      MODE_RAMP  = 2'd1,
      MODE_QUANT = 2'd2,
      MODE_RSVD  = 2'd3
   } modeT;

   typedef enum logic [1:0] {
      RAMP_TOP    = 2'd0,
      RAMP_BAND   = 2'd1,
      RAMP_BOTTOM = 2'd2
   } rampStateT;

   logic                         frameStart;
   logic                         lineStart;
   modeT                         shMode;
   logic [DATA_W-1:0]            shTop;
   logic [DATA_W-1:0]            shBot;
   logic [NQ*DATA_W-1:0]         shQ;
   logic [DATA_W-1:0]            effTop;
   logic [DATA_W-1:0]            effBot;
   logic signed [DATA_W:0]       threshDiff;
   logic signed [ACC_W-1:0]      diffWide;
   logic signed [ACC_W-1:0]      step;
   logic signed [ACC_W-1:0]      topAcc;
   logic signed [ACC_W-1:0]      botAcc;
   logic signed [ACC_W-1:0]      acc;
   logic signed [ACC_W-1:0]      accNext;
   logic signed [ACC_W-1:0]      accSum;
   logic                         accOvershoot;
   rampStateT                    rampState;
   rampStateT                    rampNext;
   logic                         s1Valid;
   logic [DATA_W-1:0]            s1Gray;
   logic [COORD_W-1:0]           s1X;
   logic [COORD_W-1:0]           s1Y;
   logic [DATA_W-1:0]            rampThr;
   logic [DATA_W-1:0]            splitThr;
   logic [LVL_W-1:0]             qLevel;
   logic [LVL_W*DATA_W-1:0]      qRep;
   logic [DATA_W-1:0]            nextPixel;
   logic [LVL_W-1:0]             nextLevel;

   assign frameStart = iValid && (iX_Cont == '0) && (iY_Cont == '0);
   assign lineStart  = iValid && (iX_Cont == '0);

   // The frame-start pixel already uses the freshly presented settings.
   assign effTop = frameStart ? iThreshTop : shTop;
   assign effBot = frameStart ? iThreshBot : shBot;

   assign threshDiff   = $signed({1'b0, effBot}) - $signed({1'b0, effTop});
   assign diffWide     = {{(ACC_W-DATA_W-1){threshDiff[DATA_W]}}, threshDiff};
   assign step         = (diffWide <<< FRAC_W) >>> (BAND_LOG2 + 1);
   assign topAcc       = $signed({2'b00, effTop, {FRAC_W{1'b0}}});
   assign botAcc       = $signed({2'b00, effBot, {FRAC_W{1'b0}}});
   assign accSum       = acc + step;
   assign accOvershoot = step[ACC_W-1] ? (accSum < botAcc) : (accSum > botAcc);
   assign rampThr      = acc[FRAC_W +: DATA_W];

   // Shadow copies of mode and thresholds, reloaded only at frame start so mid-frame writes cannot tear.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         shMode <= MODE_SPLIT;
         shTop  <= '0;
         shBot  <= '0;
         shQ    <= '0;
      end else if (frameStart) begin
         shMode <= modeT'(iMode);
         shTop  <= iThreshTop;
         shBot  <= iThreshBot;
         shQ    <= iQThresh;
      end
   end

   // Ramp FSM next state: region picked from the row at each line start, band rows step and saturate at Bot.
   always_comb begin
      rampNext = rampState;
      accNext  = acc;
      if (frameStart) begin
         rampNext = RAMP_TOP;
         accNext  = topAcc;
      end else if (lineStart) begin
         if (iY_Cont <= BAND_LO) begin
            rampNext = RAMP_TOP;
            accNext  = topAcc;
         end else if (iY_Cont >= BAND_HI) begin
            rampNext = RAMP_BOTTOM;
            accNext  = botAcc;
         end else begin
            rampNext = RAMP_BAND;
            accNext  = accOvershoot ? botAcc : accSum;
         end
      end
   end

   // Ramp FSM state and accumulator; the accumulator is aligned with the stage-1 pixel.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         rampState <= RAMP_TOP;
         acc       <= '0;
      end else begin
         rampState <= rampNext;
         acc       <= accNext;
      end
   end

   // Stage 1 captures the pixel and its coordinates whenever the input is qualified.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         s1Valid <= 1'b0;
         s1Gray  <= '0;
         s1X     <= '0;
         s1Y     <= '0;
      end else begin
         s1Valid <= iValid;
         if (iValid) begin
            s1Gray <= iGray;
            s1X    <= iX_Cont;
            s1Y    <= iY_Cont;
         end
      end
   end

   // Stage 2 decision: split/ramp binarise against one threshold, quantiser counts exceeded slices.
   always_comb begin
      splitThr  = (s1Y < SPLIT_ROW) ? shTop : shBot;
      qLevel    = '0;
      for (int k = 0; k < NQ; k++) begin
         if (s1Gray >= shQ[k*DATA_W +: DATA_W]) begin
            qLevel = qLevel + LVL_W'(1);
         end
      end
      qRep      = {DATA_W{qLevel}};
      nextPixel = '0;
      nextLevel = '0;
      case (shMode)
         MODE_RAMP: begin
            nextPixel = (s1Gray >= rampThr) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
         end
         MODE_QUANT: begin
            nextLevel = qLevel;
            nextPixel = qRep[LVL_W*DATA_W-1 -: DATA_W];
         end
         default: begin
            nextPixel = (s1Gray >= splitThr) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
         end
      endcase
   end

   // Output registers follow the valid flag every cycle and otherwise hold the last pixel.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         oValid  <= 1'b0;
         oPixel  <= '0;
         oLevel  <= '0;
         oX_Cont <= '0;
         oY_Cont <= '0;
      end else begin
         oValid <= s1Valid;
         if (s1Valid) begin
            oPixel  <= nextPixel;
            oLevel  <= nextLevel;
            oX_Cont <= s1X;
            oY_Cont <= s1Y;
         end
      end
   end

endmodule

// File: doc/multi_level_thresh.md
Name: multi_level_thresh

Overview:
- Parametrised successor to the two-threshold camera binariser in the CameraLCD pixel path; sits between the grayscale converter and the LCD/SDRAM writer.
- Three modes, selected per frame:
  - Split binarisation: top/bottom threshold by row.
  - Ramped binarisation: the threshold slides linearly between the two across a programmable band of rows.
  - Multi-level quantisation: NUM_LEVELS output levels.
- Thresholds and mode are shadow-latched at frame start, so register writes mid-frame never tear an image.

Parameters:
- DATA_W, 8, gray/pixel width.
- COORD_W, 16, width of X/Y counters.
- NUM_LEVELS, 4, quantiser output levels; power of two, 2..16.
- SPLIT_Y, 240, row where top region ends.
- BAND_LOG2, 6, half-band height = 2^BAND_LOG2 rows; ramp spans 2^(BAND_LOG2+1) rows.
- FRAC_W, 20, fractional bits of the ramp accumulator.

Ports:
- iClk  in  1  pixel clock.
- iRst_n  in  1  asynchronous active-low reset.
- iValid  in  1  pixel qualifier.
- iGray  in  DATA_W  gray pixel.
- iX_Cont  in  COORD_W  column of iGray.
- iY_Cont  in  COORD_W  row of iGray.
- iMode  in  2  0=SPLIT, 1=RAMP, 2=QUANT, 3=reserved (behaves as SPLIT).
- iThreshTop  in  DATA_W  threshold for the top region / ramp start.
- iThreshBot  in  DATA_W  threshold for the bottom region / ramp end.
- iQThresh  in  (NUM_LEVELS-1)*DATA_W  packed ascending quantiser thresholds; slice k = threshold k.
- oPixel  out  DATA_W  output pixel.
- oLevel  out  log2(NUM_LEVELS)  quantiser index; 0 in SPLIT/RAMP.
- oValid  out  1  delayed iValid.
- oX_Cont, oY_Cont  out  COORD_W  coordinates aligned with oPixel.

Behaviour:
- Reset (async assert, sync release): oPixel=0, oLevel=0, oValid=0, oX/oY=0.
  - All shadow registers clear to 0 (mode SPLIT, thresholds 0), so before the first frame start every pixel maps to all-ones.
  - Ramp FSM resets to TOP with acc=0.
  - Reset mid-frame discards the in-flight pipeline; the block resumes at the next frame start.
- Frame start = iValid && iX_Cont==0 && iY_Cont==0.
  - At frame start, shadow mode/thresholds load from the inputs, and that same pixel already uses the new values.
  - Otherwise the input values are ignored.
- Line start = iValid && iX_Cont==0. Coordinates are only sampled when iValid=1.
- Pipeline: fixed 2-cycle latency, no back-pressure.
  - Stage 1 registers gray and coordinates, and updates the ramp accumulator on line start.
  - Stage 2 compares and drives the outputs.
  - oValid, oX_Cont and oY_Cont follow iValid and the coordinates by exactly 2 cycles.
  - Outputs hold their last value while oValid=0.
- SPLIT:
  - threshold = Top if y<SPLIT_Y, else Bot.
  - oPixel = all-ones if gray >= threshold, else 0.
- RAMP FSM (state changes only on line start):
  - TOP: y <= SPLIT_Y-2^BAND_LOG2. acc = Top<<FRAC_W.
  - BAND: SPLIT_Y-2^BAND_LOG2 < y < SPLIT_Y+2^BAND_LOG2. acc += step.
  - BOTTOM: y >= SPLIT_Y+2^BAND_LOG2. acc = Bot<<FRAC_W.
  - Frame start forces TOP.
- Ramp arithmetic:
  - step = ((Bot-Top) as signed) << FRAC_W, arithmetic-shifted right by BAND_LOG2+1. It is signed, so the ramp may rise or fall.
  - acc is signed, DATA_W+FRAC_W+2 bits.
  - Each BAND update saturates at Bot<<FRAC_W; the ramp never overshoots.
  - threshold = acc >> FRAC_W (floor). The new acc applies from the line-start pixel itself.
  - Top==Bot gives step 0 and a constant threshold.
- QUANT:
  - oLevel = number of slices k with gray >= iQThresh[k]; non-ascending thresholds still give this count.
  - oPixel = oLevel bits replicated MSB-first to fill DATA_W.

Test Plan:
- RAMP, defaults, Top=200, Bot=100:
  - Rows <=176: threshold 200; row 177: threshold 199 (acc 199.21875).
  - Row 177: gray 199 -> 255, gray 198 -> 0.
  - Row 303: threshold 100; rows >=304: threshold 100, no undershoot.
- RAMP, Top=50, Bot=250: threshold rises monotonically and never exceeds 250; Top=Bot=128 gives constant 128 on every row.
- SPLIT, Top=150, Bot=60, gray=100: row 239 -> 0, row 240 -> 255, 2 cycles after input with oY_Cont matching.
- QUANT, NUM_LEVELS=4, thresholds 64/128/192:
  - gray 0 -> level 0, pixel 0x00.
  - gray 127 -> level 1, pixel 0x55.
  - gray 128 -> level 2, pixel 0xAA.
  - gray 255 -> level 3, pixel 0xFF.
- Change iMode/thresholds mid-frame -> no effect until the next x=0,y=0 pixel, which already uses the new values.
- Assert iRst_n low mid-line: outputs 0 immediately; after release, oValid stays 0 until 2 cycles after the next valid pixel; the pipeline restarts cleanly at the next frame.
